// File: rtl/router_defs.sv
// Shared definitions for the router packet transmitter: FSM encodings,
// header field layout and buffer sizing.
package router_defs;

  localparam int MAX_LEN = 63;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HEADER  = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_PARITY  = 2'd3;

  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;

  function automatic logic [7:0] make_header(input logic [5:0] len, input logic [1:0] addr);
    logic [7:0] hdr;
    hdr = '0;
    hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
    hdr[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
    return hdr;
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: single write port, registered read port whose output always
// holds the byte at the read pointer, so the consumer can take it on any edge.
import router_defs::*;

module router_tx_buf #(
  parameter int DEPTH = MAX_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_adv,
  input  logic       clear,
  output logic [5:0] count,
  output logic [7:0] rd_data
);

  localparam logic [5:0] DEPTH_CNT = 6'(DEPTH);

  logic [7:0] mem [0:DEPTH-1];
  logic [5:0] wr_ptr;
  logic [5:0] rd_ptr;
  logic [5:0] rd_next;
  logic       do_write;

  assign do_write = wr_en && (wr_ptr != DEPTH_CNT);
  assign count    = wr_ptr;

  always_comb begin
    rd_next = rd_ptr;
    if (clear)
      rd_next = '0;
    else if (rd_adv)
      rd_next = rd_ptr + 6'd1;
  end

  always_ff @(posedge clk) begin
    if (do_write)
      mem[wr_ptr] <= wr_data;
  end

  // Read data follows the next pointer so it is valid the cycle after an advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (clear)
        wr_ptr <= '0;
      else if (do_write)
        wr_ptr <= wr_ptr + 6'd1;
      rd_ptr  <= rd_next;
      rd_data <= (rd_next < DEPTH_CNT) ? mem[rd_next] : 8'h00;
    end
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Router source-side transmitter: buffers a payload, then sends header,
// payload and XOR parity onto the router input bus, honouring busy.
import router_defs::*;

module router_pkt_tx #(
  parameter int MAX_LEN = router_defs::MAX_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       tx_active,
  output logic [5:0] count,
  output logic       done,
  output logic       err
);

  localparam logic [5:0] MAX_CNT = 6'(MAX_LEN);

  logic [1:0] state;
  logic [5:0] len_r;
  logic [5:0] remaining;
  logic [7:0] parity;
  logic [7:0] rd_data;
  logic       buf_wr;
  logic       rd_adv;
  logic       buf_clear;

  assign buf_wr    = (state == ST_IDLE) && wr_en && !start;
  assign rd_adv    = !busy && ((state == ST_HEADER) || (state == ST_PAYLOAD));
  assign buf_clear = !busy && (state == ST_PARITY);

  router_tx_buf #(.DEPTH(MAX_LEN)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (buf_wr),
    .wr_data (wr_data),
    .rd_adv  (rd_adv),
    .clear   (buf_clear),
    .count   (count),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      len_r     <= '0;
      remaining <= '0;
      parity    <= '0;
      data_out  <= '0;
      pkt_valid <= 1'b0;
      tx_active <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Start wins over a simultaneous write; the write is silently dropped.
          if (start) begin
            if ((count == 6'd0) || (dest_addr == ADDR_INVALID)) begin
              err <= 1'b1;
            end else begin
              len_r     <= count;
              parity    <= make_header(count, dest_addr);
              data_out  <= make_header(count, dest_addr);
              pkt_valid <= 1'b1;
              tx_active <= 1'b1;
              state     <= ST_HEADER;
            end
          end else if (wr_en && (count == MAX_CNT)) begin
            err <= 1'b1;
          end
        end
        ST_HEADER: begin
          if (!busy) begin
            data_out  <= rd_data;
            parity    <= parity ^ rd_data;
            remaining <= len_r - 6'd1;
            state     <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (!busy) begin
            if (remaining != 6'd0) begin
              data_out  <= rd_data;
              parity    <= parity ^ rd_data;
              remaining <= remaining - 6'd1;
            end else begin
              data_out  <= parity;
              pkt_valid <= 1'b0;
              state     <= ST_PARITY;
            end
          end
        end
        default: begin
          if (!busy) begin
            data_out  <= '0;
            tx_active <= 1'b0;
            done      <= 1'b1;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: IDLE-side vector table plus
// scoreboarded packet sequences with stalls, writes during tx and reset abort.
module tb_router_pkt_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       start;
  logic [1:0] dest_addr;
  logic       busy;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       tx_active;
  logic [5:0] count;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_q[$];
  logic [7:0] payload[63];

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       st;
    logic [1:0] a;
    logic [5:0] cnt;
    logic       er;
  } vec_t;

  vec_t vecs[6];

  router_pkt_tx dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .start     (start),
    .dest_addr (dest_addr),
    .busy      (busy),
    .data_out  (data_out),
    .pkt_valid (pkt_valid),
    .tx_active (tx_active),
    .count     (count),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // One clock: score the byte on the bus (accepted or stalled), then advance.
  task automatic tick();
    if (tx_active) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL stream_extra: actual=0x%0h required=none", {pkt_valid, data_out});
      end else if (!busy) begin
        check("stream_byte", {23'b0, pkt_valid, data_out}, {23'b0, exp_q.pop_front()});
      end else begin
        check("stall_hold", {23'b0, pkt_valid, data_out}, {23'b0, exp_q[0]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic send(input int n, input logic [1:0] a, input int stall_from, input int stall_n,
                      input int abort_at, input int wr_at);
    logic [7:0] hdr;
    logic [7:0] par;
    int         cycles;
    bit         done_seen;
    bit         aborted;
    hdr = {n[5:0], a};
    par = hdr;
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = payload[i];
      tick();
    end
    wr_en = 1'b0;
    check("count_loaded", 32'(count), 32'(n));
    exp_q.push_back({1'b1, hdr});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b1, payload[i]});
      par = par ^ payload[i];
    end
    exp_q.push_back({1'b0, par});
    start     = 1'b1;
    dest_addr = a;
    tick();
    start = 1'b0;
    check("header_first", {23'b0, tx_active, pkt_valid, data_out}, {23'b0, 2'b11, hdr});
    cycles    = 0;
    done_seen = 1'b0;
    aborted   = 1'b0;
    while (cycles < 300 && !done_seen && !aborted) begin
      busy      = (cycles >= stall_from) && (cycles < stall_from + stall_n);
      wr_en     = (cycles == wr_at);
      start     = (cycles == wr_at);
      wr_data   = 8'hAA;
      dest_addr = 2'd1;
      rst       = (cycles == abort_at);
      tick();
      busy  = 1'b0;
      wr_en = 1'b0;
      start = 1'b0;
      if (cycles == abort_at) begin
        rst     = 1'b0;
        aborted = 1'b1;
        check("abort_outputs", {21'b0, data_out, pkt_valid, tx_active, done},
              32'd0);
        check("abort_count", 32'(count), 32'd0);
        exp_q.delete();
        tick();
        check("abort_no_done", {30'b0, done, tx_active}, 32'd0);
      end else if (done) begin
        done_seen = 1'b1;
      end else begin
        check("tx_err_quiet", 32'(err), 32'd0);
        if (tx_active)
          check("tx_count_hold", 32'(count), 32'(n));
      end
      cycles++;
    end
    if (!aborted) begin
      check("done_seen", 32'(done_seen), 32'd1);
      check("occupancy", 32'(cycles), 32'(n + 2 + stall_n));
      check("stream_left", 32'(exp_q.size()), 32'd0);
      check("count_cleared", 32'(count), 32'd0);
      check("idle_after", {30'b0, tx_active, pkt_valid}, 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    rst       = 1'b0;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    start     = 1'b0;
    dest_addr = 2'd0;
    busy      = 1'b0;
    #1;
    apply_reset();
    check("reset_outputs", {19'b0, data_out, pkt_valid, tx_active, done, err, 1'b0},
          32'd0);
    check("reset_count", 32'(count), 32'd0);

    // IDLE-side vectors: expected count/err after the edge.
    vecs[0] = '{wr: 1'b0, d: 8'h00, st: 1'b1, a: 2'd1, cnt: 6'd0, er: 1'b1};
    vecs[1] = '{wr: 1'b1, d: 8'h55, st: 1'b0, a: 2'd0, cnt: 6'd1, er: 1'b0};
    vecs[2] = '{wr: 1'b0, d: 8'h00, st: 1'b1, a: 2'd3, cnt: 6'd1, er: 1'b1};
    vecs[3] = '{wr: 1'b1, d: 8'h66, st: 1'b1, a: 2'd3, cnt: 6'd1, er: 1'b1};
    vecs[4] = '{wr: 1'b1, d: 8'h66, st: 1'b0, a: 2'd0, cnt: 6'd2, er: 1'b0};
    vecs[5] = '{wr: 1'b0, d: 8'h00, st: 1'b0, a: 2'd0, cnt: 6'd2, er: 1'b0};
    for (int i = 0; i < 6; i++) begin
      wr_en     = vecs[i].wr;
      wr_data   = vecs[i].d;
      start     = vecs[i].st;
      dest_addr = vecs[i].a;
      tick();
      wr_en = 1'b0;
      start = 1'b0;
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].er));
      check($sformatf("vec%0d_idle", i), {30'b0, tx_active, pkt_valid}, 32'd0);
    end
    apply_reset();

    $display("[TB] basic 3-byte packet to port 2");
    payload[0] = 8'h11;
    payload[1] = 8'h22;
    payload[2] = 8'h33;
    send(3, 2'd2, 1000, 0, -1, -1);
    start     = 1'b1;
    dest_addr = 2'd1;
    tick();
    start = 1'b0;
    check("start_on_done_empty_err", 32'(err), 32'd1);
    check("start_on_done_idle", 32'(tx_active), 32'd0);

    $display("[TB] same packet, busy 3 cycles on 0x22, write attempt mid-packet");
    send(3, 2'd2, 2, 3, -1, -1);
    send(3, 2'd2, 1000, 0, -1, 1);

    $display("[TB] full buffer: 64 writes");
    for (int i = 0; i < 64; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i * 7 + 3);
      if (i < 63)
        payload[i] = 8'(i * 7 + 3);
      tick();
      check($sformatf("fill_err_%0d", i), 32'(err), 32'(i == 63));
    end
    wr_en = 1'b0;
    check("fill_count", 32'(count), 32'd63);
    apply_reset();
    send(63, 2'd0, 1000, 0, -1, -1);

    $display("[TB] reset during 5th payload byte of a 14-byte packet");
    for (int i = 0; i < 14; i++)
      payload[i] = 8'($urandom_range(0, 255));
    send(14, 2'd2, 1000, 0, 5, -1);

    $display("[TB] packet after abort, random payload with stall");
    for (int i = 0; i < 9; i++)
      payload[i] = 8'($urandom_range(0, 255));
    send(9, 2'd1, 4, 2, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
